spi_reg_slave: RTL and testbench

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 57 +++++
 rtl/spi_reg_slave.sv | 189 ++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI register slave:
//   spi_state_t       - transaction FSM states (IDLE, CMD, WDATA, RDATA)
//   CMD_WRITE_BIT     - bit of the command byte that selects write (1) or read (0)
//   DEFAULT_NUM_REGS  - default size of the 8-bit register bank
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int DEFAULT_NUM_REGS = 4;
    localparam int CMD_WRITE_BIT    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchronizer for one asynchronous input, with optional single-clk
// rise/fall pulses derived from the synchronized value.
//   clk, reset - system clock, asynchronous active-high reset
//   d          - asynchronous input
//   q          - synchronized level (preset to RESET_VAL on reset)
//   rise, fall - one-clk pulses on synchronized edges (tied low if EDGE_EN=0)
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter bit RESET_VAL = 1'b0,
    parameter bit EDGE_EN   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

    generate
        if (EDGE_EN) begin : g_edge
            logic prev;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    prev <= RESET_VAL;
                end else begin
                    prev <= sync;
                end
            end

            assign rise = sync & ~prev;
            assign fall = ~sync & prev;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_reg_slave.sv
// -----------------------------------------------------------------------------
// spi_reg_slave
// SPI slave (all four CPOL/CPHA modes) giving a master byte-wise access to a
// bank of NUM_REGS 8-bit registers. SCLK/MOSI/SS are oversampled in the clk
// domain. First byte of a transaction is a command: bit 7 = 1 write, 0 read;
// low ADDR_W bits = start address. Following bytes are written to, or read
// from, consecutive addresses with wrap-around.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   cpol, cpha  - SPI mode, stable while SS is low
//   SCLK, MOSI, SS - SPI master inputs (asynchronous to clk)
//   MISO        - serial read data, MSB first, 0 outside read data bytes
//   reg_out     - register bank, reg[i] at bits [8i+7:8i]
//   wr_strobe   - one-clk pulse per byte written into the bank
//   wr_addr     - address of that write
//   fsm_state   - current transaction state (debug visibility)
// -----------------------------------------------------------------------------
module spi_reg_slave
    import spi_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  SS,
    output logic                  MISO,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr,
    output spi_state_t            fsm_state
);

    // ---------------- input synchronization ----------------
    logic       sclk_s, sclk_rise, sclk_fall;
    logic       ss_s, ss_rise, ss_fall;
    logic       mosi_s;
    logic [1:0] mosi_edges_unused;

    spi_sync_edge #(.RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(SCLK),
        .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1), .EDGE_EN(1'b1)) u_sync_ss (
        .clk(clk), .reset(reset), .d(SS),
        .q(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(MOSI),
        .q(mosi_s), .rise(mosi_edges_unused[0]), .fall(mosi_edges_unused[1])
    );

    // ---------------- edge classification ----------------
    // Just after a leading edge SCLK sits away from its idle level (cpol);
    // just after a trailing edge it is back at idle.
    logic sclk_any, lead_edge, trail_edge;
    logic sample_edge, shift_edge;

    spi_state_t state, next_state;

    assign sclk_any    = sclk_rise | sclk_fall;
    assign lead_edge   = sclk_any &  (sclk_s ^ cpol);
    assign trail_edge  = sclk_any & ~(sclk_s ^ cpol);
    assign sample_edge = (state != IDLE) & (cpha ? trail_edge : lead_edge);
    assign shift_edge  = (state != IDLE) & (cpha ? lead_edge  : trail_edge);

    // ---------------- datapath state ----------------
    logic [7:0]        regs [NUM_REGS];
    logic [7:0]        rx_shift;
    logic [7:0]        tx_shift;
    logic [2:0]        bit_cnt;
    logic [ADDR_W-1:0] ptr;

    logic [7:0]        rx_byte;
    logic              byte_done;
    logic [ADDR_W-1:0] cmd_addr;

    assign rx_byte   = {rx_shift[6:0], mosi_s};
    assign byte_done = sample_edge && (bit_cnt == 3'd7);
    assign cmd_addr  = rx_byte[ADDR_W-1:0];

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        if (int'(p) == NUM_REGS - 1) return '0;
        return p + 1'b1;
    endfunction

    function automatic logic [7:0] reg_rd(input logic [ADDR_W-1:0] idx);
        if (int'(idx) < NUM_REGS) return regs[idx];
        return 8'h00;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ss_fall) next_state = CMD;
            end
            CMD: begin
                if (byte_done) next_state = rx_byte[CMD_WRITE_BIT] ? WDATA : RDATA;
            end
            default: begin
            end
        endcase
        // A byte completing in the same clk is still handled by the datapath
        // below; the FSM then leaves the transaction.
        if (ss_rise) next_state = IDLE;
    end

    assign fsm_state = state;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
            rx_shift  <= 8'h00;
            tx_shift  <= 8'h00;
            bit_cnt   <= 3'd0;
            ptr       <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            MISO      <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;

            if (state == IDLE) begin
                if (ss_fall) bit_cnt <= 3'd0;
            end else begin
                if (sample_edge) begin
                    rx_shift <= rx_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                end

                if (byte_done) begin
                    case (state)
                        CMD: begin
                            if (rx_byte[CMD_WRITE_BIT]) begin
                                ptr <= cmd_addr;
                            end else begin
                                tx_shift <= reg_rd(cmd_addr);
                                ptr      <= ptr_next(cmd_addr);
                            end
                        end
                        WDATA: begin
                            if (int'(ptr) < NUM_REGS) regs[ptr] <= rx_byte;
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            ptr       <= ptr_next(ptr);
                        end
                        RDATA: begin
                            tx_shift <= reg_rd(ptr);
                            ptr      <= ptr_next(ptr);
                        end
                        default: begin
                        end
                    endcase
                end else if (shift_edge && (state == RDATA) && (bit_cnt != 3'd0)) begin
                    // A shift edge seen with bit_cnt==0 is either the one that
                    // closes a byte (cpha=0) or the first edge of a byte
                    // (cpha=1); in both cases the freshly loaded MSB must stay.
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end

            MISO <= ((state == RDATA) && !ss_s) ? tx_shift[7] : 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
            assign reg_out[8*i +: 8] = regs[i];
        end
    endgenerate

endmodule

// File: tb/tb_spi_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_slave
// Bench for spi_reg_slave: an SPI master driven from tasks, a register-bank
// reference model kept as a plain array, and a write-strobe monitor.
// -----------------------------------------------------------------------------
module tb_spi_reg_slave;
    import spi_pkg::*;

    localparam int NR   = 4;
    localparam int AW   = 2;
    localparam int HALF = 8;   // clk cycles per SCLK half period

    logic              clk = 1'b0;
    logic              reset;
    logic              cpol, cpha, sclk, mosi, ss;
    logic              miso;
    logic [8*NR-1:0]   reg_out;
    logic              wr_strobe;
    logic [AW-1:0]     wr_addr;
    spi_state_t        fsm_state;

    int total = 0;
    int bad   = 0;

    logic [7:0]    model [NR];
    logic [7:0]    tx_q[$];
    logic [7:0]    rx_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [AW-1:0] obs_addr_q[$];

    always #5 clk = ~clk;

    spi_reg_slave #(.NUM_REGS(NR), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
        .SCLK(sclk), .MOSI(mosi), .SS(ss), .MISO(miso),
        .reg_out(reg_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .fsm_state(fsm_state)
    );

    // strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) obs_addr_q.push_back(wr_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[8*i +: 8] = model[i];
        return v;
    endfunction

    task automatic set_mode(input logic pol, input logic pha);
        cpol = pol;
        cpha = pha;
        sclk = pol;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_low();
        ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (HALF) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // shifts the top nbits of tx, MSB first; rx collects what MISO showed
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                mosi = tx[i];
                repeat (HALF) @(negedge clk);
                sclk  = ~cpol;
                rx[i] = miso;
                repeat (HALF) @(negedge clk);
                sclk  = cpol;
            end else begin
                repeat (HALF) @(negedge clk);
                sclk = ~cpol;
                mosi = tx[i];
                repeat (HALF) @(negedge clk);
                sclk  = cpol;
                rx[i] = miso;
            end
        end
    endtask

    // Runs tx_q as one transaction and checks it against the model.
    task automatic run_txn(input string tag);
        logic [7:0]    r;
        logic [7:0]    exp_rx[$];
        logic [AW-1:0] a;
        logic [7:0]    c;
        logic          wr;
        int            n;
        c  = tx_q[0];
        wr = c[7];
        a  = c[AW-1:0];
        exp_rx.delete();
        exp_addr_q.delete();
        obs_addr_q.delete();
        rx_q.delete();
        exp_rx.push_back(8'h00);
        for (int k = 1; k < tx_q.size(); k++) begin
            if (wr) begin
                exp_rx.push_back(8'h00);
                model[a] = tx_q[k];
                exp_addr_q.push_back(a);
            end else begin
                exp_rx.push_back(model[a]);
            end
            a = AW'((int'(a) + 1) % NR);
        end

        ss_low();
        for (int k = 0; k < tx_q.size(); k++) begin
            xfer(tx_q[k], 8, r);
            rx_q.push_back(r);
        end
        ss_high();

        for (int k = 0; k < rx_q.size(); k++)
            check($sformatf("%s_rx%0d", tag, k), 32'(rx_q[k]), 32'(exp_rx[k]));
        check($sformatf("%s_nstrobe", tag), 32'(obs_addr_q.size()), 32'(exp_addr_q.size()));
        n = (obs_addr_q.size() < exp_addr_q.size()) ? obs_addr_q.size() : exp_addr_q.size();
        for (int k = 0; k < n; k++)
            check($sformatf("%s_waddr%0d", tag, k), 32'(obs_addr_q[k]), 32'(exp_addr_q[k]));
        check($sformatf("%s_bank", tag), reg_out, model_vec());
        check($sformatf("%s_idle", tag), 32'(fsm_state), 32'(IDLE));
        check($sformatf("%s_miso_idle", tag), 32'(miso), 32'd0);
    endtask

    initial begin
        logic [7:0] r;
        int         m;
        int         len;

        // ---------------- reset ----------------
        reset = 1'b1;
        ss    = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        cpol  = 1'b0;
        cpha  = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_bank", reg_out, 32'h0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_waddr", 32'(wr_addr), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // ---------------- mode 0 burst write ----------------
        set_mode(1'b0, 1'b0);
        tx_q = '{8'h80, 8'h10, 8'h20, 8'h30, 8'h40};
        run_txn("wr_m0");
        check("wr_m0_const", reg_out, 32'h40302010);

        // ---------------- mode 0 burst read ----------------
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn("rd_m0");
        check("rd_m0_byte1", 32'(rx_q[1]), 32'h10);
        check("rd_m0_byte4", 32'(rx_q[4]), 32'h40);

        // ---------------- address wrap ----------------
        tx_q = '{8'h83, 8'hAA, 8'hBB};
        run_txn("wrap_wr");
        check("wrap_reg3", 32'(reg_out[31:24]), 32'hAA);
        check("wrap_reg0", 32'(reg_out[7:0]), 32'hBB);
        tx_q = '{8'h03, 8'h00, 8'h00};
        run_txn("wrap_rd");

        // ---------------- abort mid-byte ----------------
        obs_addr_q.delete();
        ss_low();
        xfer(8'h81, 8, r);
        xfer(8'hFF, 5, r);
        ss_high();
        check("abort_nstrobe", 32'(obs_addr_q.size()), 32'd0);
        check("abort_bank", reg_out, model_vec());
        check("abort_state", 32'(fsm_state), 32'(IDLE));

        // ---------------- other SPI modes ----------------
        set_mode(1'b1, 1'b1);
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn("rd_m3");
        set_mode(1'b0, 1'b1);
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn("rd_m1");
        set_mode(1'b1, 1'b0);
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn("rd_m2");
        set_mode(1'b1, 1'b1);
        tx_q = '{8'h82, 8'h5A, 8'hC3};
        run_txn("wr_m3");

        // ---------------- randomized transactions ----------------
        for (int t = 0; t < 14; t++) begin
            m   = $urandom_range(0, 3);
            len = $urandom_range(1, 5);
            set_mode(m[1], m[0]);
            tx_q.delete();
            tx_q.push_back(8'($urandom));
            for (int k = 0; k < len; k++) tx_q.push_back(8'($urandom));
            run_txn($sformatf("rnd%0d_m%0d", t, m));
        end

        // ---------------- reset in the middle of a read ----------------
        set_mode(1'b0, 1'b0);
        tx_q = '{8'h80, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
        run_txn("pre_rst_wr");
        ss_low();
        xfer(8'h00, 8, r);
        xfer(8'h00, 3, r);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_miso", 32'(miso), 32'd0);
        check("midrst_bank", reg_out, 32'h0);
        check("midrst_state", 32'(fsm_state), 32'(IDLE));
        ss   = 1'b1;
        sclk = cpol;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        repeat (4) @(negedge clk);
        tx_q = '{8'h80, 8'h10, 8'h20, 8'h30, 8'h40};
        run_txn("post_rst_wr");
        check("post_rst_const", reg_out, 32'h40302010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
